// File: rtl/pc_sequencer_if.sv
// Purpose: decode-side bundle for the program-counter / return-stack sequencer.
// Ports (members):
//   en, jmp, ret, target, clr_err : controls from decode into the sequencer
//   pc, depth                     : registered sequencer state
//   stack_full, stack_empty       : decoded from depth
//   ovf_err, unf_err              : sticky stack error flags
// Modports: master = decode side, slave = sequencer.
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);

  logic               en;
  logic               jmp;
  logic               ret;
  logic [ADDR_W-1:0]  target;
  logic               clr_err;
  logic [ADDR_W-1:0]  pc;
  logic [DEPTH_W-1:0] depth;
  logic               stack_full;
  logic               stack_empty;
  logic               ovf_err;
  logic               unf_err;

  modport master (
    output en, jmp, ret, target, clr_err,
    input  pc, depth, stack_full, stack_empty, ovf_err, unf_err
  );

  modport slave (
    input  en, jmp, ret, target, clr_err,
    output pc, depth, stack_full, stack_empty, ovf_err, unf_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Purpose: program counter with a LIFO return-address stack. Jumps push pc+1
// and load target, returns pop the saved address, otherwise pc increments.
// Overflow/underflow are latched in sticky flags cleared by clr_err.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : pc_sequencer_if.slave (controls in, pc/depth/flags out)
module pc_sequencer #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);

  localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0]  r_stack [DEPTH];
  logic [ADDR_W-1:0]  r_pc;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_ovf_err;
  logic               r_unf_err;

  logic [ADDR_W-1:0]  w_pc_inc;
  logic [ADDR_W-1:0]  w_pc_nxt;
  logic [DEPTH_W-1:0] w_depth_nxt;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_ovf_set;
  logic               w_unf_set;
  logic [PTR_W-1:0]   w_top_idx;
  logic [PTR_W-1:0]   w_push_idx;

  // Status decoded purely from the registered depth.
  assign w_full     = (r_depth == DEPTH_W'(DEPTH));
  assign w_empty    = (r_depth == '0);
  assign w_pc_inc   = r_pc + ADDR_W'(1);
  // Top-of-stack is depth-1; only consulted when the stack is non-empty.
  assign w_top_idx  = PTR_W'(r_depth - DEPTH_W'(1));
  // Next free slot is depth; only written when the stack is not full.
  assign w_push_idx = PTR_W'(r_depth);

  // Next-state selection: jmp > ret > sequential, all gated by en.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_depth_nxt = r_depth;
    w_push      = 1'b0;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    if (bus.en) begin
      if (bus.jmp) begin
        w_pc_nxt = bus.target;
        if (!w_full) begin
          w_push      = 1'b1;
          w_depth_nxt = r_depth + DEPTH_W'(1);
        end else begin
          w_ovf_set = 1'b1;
        end
      end else if (bus.ret) begin
        if (!w_empty) begin
          w_pc_nxt    = r_stack[w_top_idx];
          w_depth_nxt = r_depth - DEPTH_W'(1);
        end else begin
          w_pc_nxt  = w_pc_inc;
          w_unf_set = 1'b1;
        end
      end else begin
        w_pc_nxt = w_pc_inc;
      end
    end
  end

  // PC, depth and sticky errors; a set beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= '0;
      r_depth   <= '0;
      r_ovf_err <= 1'b0;
      r_unf_err <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_depth   <= w_depth_nxt;
      r_ovf_err <= w_ovf_set | (r_ovf_err & ~bus.clr_err);
      r_unf_err <= w_unf_set | (r_unf_err & ~bus.clr_err);
    end
  end

  // Stack storage needs no reset: entries at or above depth are never read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[w_push_idx] <= w_pc_inc;
    end
  end

  assign bus.pc          = r_pc;
  assign bus.depth       = r_depth;
  assign bus.stack_full  = w_full;
  assign bus.stack_empty = w_empty;
  assign bus.ovf_err     = r_ovf_err;
  assign bus.unf_err     = r_unf_err;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  typedef struct {
    string      tag;
    logic [4:0] pc;
    logic [2:0] depth;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  pc_sequencer_if #(.ADDR_W(5), .DEPTH(4)) bus ();

  pc_sequencer #(.ADDR_W(5), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input string tag, input int pc, input int depth,
                              input logic ovf, input logic unf);
    exp_t e;
    e.tag   = tag;
    e.pc    = 5'(pc);
    e.depth = 3'(depth);
    e.full  = (depth == 4);
    e.empty = (depth == 0);
    e.ovf   = ovf;
    e.unf   = unf;
    return e;
  endfunction

  task automatic chk(input string tag, input string field, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare every output against it.
  task automatic check_front();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk(e.tag, "pc",    8'(bus.pc),          8'(e.pc));
      chk(e.tag, "depth", 8'(bus.depth),       8'(e.depth));
      chk(e.tag, "full",  8'(bus.stack_full),  8'(e.full));
      chk(e.tag, "empty", 8'(bus.stack_empty), 8'(e.empty));
      chk(e.tag, "ovf",   8'(bus.ovf_err),     8'(e.ovf));
      chk(e.tag, "unf",   8'(bus.unf_err),     8'(e.unf));
    end
  endtask

  // Drive one cycle of controls, push its expected outcome, clock, compare.
  task automatic step(input logic e, input logic j, input logic r, input int t,
                      input logic c, input exp_t ex);
    bus.en      = e;
    bus.jmp     = j;
    bus.ret     = r;
    bus.target  = 5'(t);
    bus.clr_err = c;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    check_front();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.jmp     = 1'b0;
    bus.ret     = 1'b0;
    bus.target  = '0;
    bus.clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb.push_back(mk("reset", 0, 0, 0, 0));
    check_front();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Sequential run with wrap: 1..31, 0, 1
    for (int i = 0; i < 33; i++) step(1, 0, 0, 0, 0, mk("seq", (i + 1) % 32, 0, 0, 0));

    // Call / return
    step(1, 0, 0, 0, 0, mk("seq_to2", 2, 0, 0, 0));
    step(1, 0, 0, 0, 0, mk("seq_to3", 3, 0, 0, 0));
    step(1, 1, 0, 20, 0, mk("call", 20, 1, 0, 0));
    step(1, 0, 0, 0, 0, mk("call_seq1", 21, 1, 0, 0));
    step(1, 0, 0, 0, 0, mk("call_seq2", 22, 1, 0, 0));
    step(1, 0, 1, 0, 0, mk("return", 4, 0, 0, 0));

    // Advance from 4 to 1 (wrapping) for the nested test
    for (int i = 0; i < 29; i++) step(1, 0, 0, 0, 0, mk("seq_to1", (5 + i) % 32, 0, 0, 0));

    // Nested calls with overflow
    step(1, 1, 0, 10, 0, mk("nest1", 10, 1, 0, 0));
    step(1, 1, 0, 11, 0, mk("nest2", 11, 2, 0, 0));
    step(1, 1, 0, 12, 0, mk("nest3", 12, 3, 0, 0));
    step(1, 1, 0, 13, 0, mk("nest4", 13, 4, 0, 0));
    step(1, 1, 0, 14, 0, mk("nest_ovf", 14, 4, 1, 0));
    step(1, 0, 1, 0, 0, mk("unwind1", 13, 3, 1, 0));
    step(1, 0, 1, 0, 0, mk("unwind2", 12, 2, 1, 0));
    step(1, 0, 1, 0, 0, mk("unwind3", 11, 1, 1, 0));
    step(1, 0, 1, 0, 0, mk("unwind4", 2, 0, 1, 0));
    step(1, 0, 0, 0, 1, mk("clr_ovf", 3, 0, 0, 0));

    // Underflow and clear
    for (int p = 4; p <= 7; p++) step(1, 0, 0, 0, 0, mk("seq_to7", p, 0, 0, 0));
    step(1, 0, 1, 0, 0, mk("unf", 8, 0, 0, 1));
    step(1, 0, 0, 0, 1, mk("clr_unf", 9, 0, 0, 0));
    step(1, 0, 1, 0, 1, mk("unf_beats_clr", 10, 0, 0, 1));
    step(0, 0, 0, 0, 1, mk("clr_while_stall", 10, 0, 0, 0));

    // Priority, stall, wrap of return address
    for (int p = 11; p <= 31; p++) step(1, 0, 0, 0, 0, mk("seq_to31", p, 0, 0, 0));
    step(1, 1, 1, 5, 0, mk("jmp_over_ret", 5, 1, 0, 0));
    step(0, 1, 0, 9, 0, mk("stall", 5, 1, 0, 0));
    step(1, 0, 1, 0, 0, mk("ret_wrap", 0, 0, 0, 0));

    // Build depth=3 with ovf set, then reset between edges
    step(1, 1, 0, 1, 0, mk("pre1", 1, 1, 0, 0));
    step(1, 1, 0, 2, 0, mk("pre2", 2, 2, 0, 0));
    step(1, 1, 0, 3, 0, mk("pre3", 3, 3, 0, 0));
    step(1, 1, 0, 4, 0, mk("pre4", 4, 4, 0, 0));
    step(1, 1, 0, 5, 0, mk("pre_ovf", 5, 4, 1, 0));
    step(1, 0, 1, 0, 0, mk("pre_pop", 4, 3, 1, 0));
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(mk("async_rst", 0, 0, 0, 0));
    check_front();
    #1;
    rst_n = 1'b1;
    step(1, 0, 0, 0, 0, mk("post_rst", 1, 0, 0, 0));

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
